spart_word_bridge: RTL and testbench

- Parametrised bridge between the byte-level SPART core and word-wide memory/host logic.
- RX path packs BYTES consecutive received bytes, least-significant byte first, into one word and emits a one-cycle write strobe.
- TX path runs a burst of reads from a word source and serialises each word LSB-first to the SPART with a valid/ready handshake.
- Compared with the previous controller, it adds configurable word width, programmable burst length, an RX inter-byte timeout with resync, and explicit completion status.

---
 rtl/spart_word_bridge_if.sv | 45 ++++
 rtl/spart_word_bridge.sv | 156 +++++++++++++++
 tb/tb_spart_word_bridge.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_word_bridge_if.sv
// spart_word_bridge bus bundle: SPART byte side, word sink and word source.
// The bridge takes the slave view, the surrounding logic the master view.
interface spart_word_bridge_if #(
  parameter int BYTES   = 2,
  parameter int BURST_W = 16,
  parameter int CNT_W   = 12
);
  localparam int W = 8 * BYTES;

  logic [7:0]         rx_byte;
  logic               rx_byte_vld;
  logic [W-1:0]       wr_data;
  logic               wr_vld;
  logic [7:0]         tx_byte;
  logic               tx_byte_vld;
  logic               tx_byte_rdy;
  logic               tx_start;
  logic [BURST_W-1:0] burst_len;
  logic               rd_req;
  logic [W-1:0]       rd_data;
  logic               rd_data_vld;
  logic               tx_busy;
  logic               tx_done;
  logic               rx_timeout_err;
  logic [CNT_W-1:0]   rx_word_cnt;
  logic [CNT_W-1:0]   tx_word_cnt;

  modport master (
    output rx_byte, rx_byte_vld, tx_byte_rdy,
    output tx_start, burst_len,
    output rd_data, rd_data_vld,
    input  wr_data, wr_vld, tx_byte, tx_byte_vld,
    input  rd_req, tx_busy, tx_done, rx_timeout_err,
    input  rx_word_cnt, tx_word_cnt
  );

  modport slave (
    input  rx_byte, rx_byte_vld, tx_byte_rdy,
    input  tx_start, burst_len,
    input  rd_data, rd_data_vld,
    output wr_data, wr_vld, tx_byte, tx_byte_vld,
    output rd_req, tx_busy, tx_done, rx_timeout_err,
    output rx_word_cnt, tx_word_cnt
  );
endinterface

// File: rtl/spart_word_bridge.sv
// Byte <-> word bridge for the SPART: LSB-first RX packing with
// inter-byte timeout, and burst-read TX serialisation with status.
module spart_word_bridge #(
  parameter int BYTES   = 2,
  parameter int BURST_W = 16,
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  spart_word_bridge_if.slave  bus
);
  localparam int W  = 8 * BYTES;
  localparam int LW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LW-1:0] LAST = LW'(BYTES - 1);
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;

  logic [LW-1:0]    lane;
  logic [W-1:0]     rx_buf;
  logic [W-1:0]     rx_nxt;
  logic [TW-1:0]    tcnt;
  logic             expire;
  logic [W-1:0]     wr_data_q;
  logic             wr_vld_q;
  logic             err_q;
  logic [CNT_W-1:0] rx_cnt;

  logic [1:0]         state;
  logic [BURST_W-1:0] len;
  logic [BURST_W-1:0] sent;
  logic [W-1:0]       shift;
  logic [LW-1:0]      j;
  logic               done_q;
  logic [CNT_W-1:0]   tx_cnt;
  logic [7:0]         tx_byte_c;

  always_comb begin
    rx_nxt = rx_buf;
    for (int k = 0; k < BYTES; k++)
      if (lane == LW'(k)) rx_nxt[8*k +: 8] = bus.rx_byte;
  end

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign expire = (TIMEOUT != 0) && (lane != '0) && (tcnt == TLIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      lane      <= '0;
      rx_buf    <= '0;
      tcnt      <= '0;
      wr_data_q <= '0;
      wr_vld_q  <= 1'b0;
      err_q     <= 1'b0;
      rx_cnt    <= '0;
    end else begin
      wr_vld_q <= 1'b0;
      err_q    <= 1'b0;
      if (bus.rx_byte_vld) begin
        rx_buf <= rx_nxt;
        tcnt   <= '0;
        if (lane == LAST) begin
          lane      <= '0;
          wr_data_q <= rx_nxt;
          wr_vld_q  <= 1'b1;
          rx_cnt    <= rx_cnt + CNT_W'(1);
        end else begin
          lane <= lane + LW'(1);
        end
      end else if (lane != '0) begin
        if (expire) begin
          lane  <= '0;
          tcnt  <= '0;
          err_q <= 1'b1;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      len    <= '0;
      sent   <= '0;
      shift  <= '0;
      j      <= '0;
      done_q <= 1'b0;
      tx_cnt <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.tx_start) begin
            if (bus.burst_len != '0) begin
              len   <= bus.burst_len;
              sent  <= '0;
              state <= S_REQ;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (bus.rd_data_vld) begin
            shift <= bus.rd_data;
            j     <= '0;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.tx_byte_rdy) begin
            if (j == LAST) begin
              j      <= '0;
              tx_cnt <= tx_cnt + CNT_W'(1);
              sent   <= sent + BURST_W'(1);
              if (sent + BURST_W'(1) == len) begin
                done_q <= 1'b1;
                state  <= S_IDLE;
              end else begin
                state <= S_REQ;
              end
            end else begin
              j <= j + LW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_byte_c = '0;
    for (int k = 0; k < BYTES; k++)
      if (state == S_SEND && j == LW'(k)) tx_byte_c = shift[8*k +: 8];
  end

  assign bus.wr_data        = wr_data_q;
  assign bus.wr_vld         = wr_vld_q;
  assign bus.rx_timeout_err = err_q;
  assign bus.rx_word_cnt    = rx_cnt;
  assign bus.tx_byte        = tx_byte_c;
  assign bus.tx_byte_vld    = (state == S_SEND);
  assign bus.rd_req         = (state == S_REQ);
  assign bus.tx_busy        = (state != S_IDLE);
  assign bus.tx_done        = done_q;
  assign bus.tx_word_cnt    = tx_cnt;
endmodule

// File: tb/tb_spart_word_bridge.sv
// Directed bench for spart_word_bridge: a 2-byte instance (short timeout,
// 4-bit counters) and a 4-byte instance for the TX burst scenarios.
module tb_spart_word_bridge;
  logic clk = 1'b0;
  logic rst2;
  logic rst4;
  always #5 clk = ~clk;

  spart_word_bridge_if #(.BYTES(2), .BURST_W(16), .CNT_W(4))  b2();
  spart_word_bridge_if #(.BYTES(4), .BURST_W(16), .CNT_W(12)) b4();

  spart_word_bridge #(.BYTES(2), .BURST_W(16), .CNT_W(4), .TIMEOUT(8))
    dut2 (.clk(clk), .rst(rst2), .bus(b2));
  spart_word_bridge #(.BYTES(4), .BURST_W(16), .CNT_W(12))
    dut4 (.clk(clk), .rst(rst4), .bus(b4));

  int passed = 0;
  int total  = 0;
  int n_wr2, n_err2, n_wr4, n_req4, n_done4, unstable;
  int reached;
  logic [7:0]  txq[$];
  logic [31:0] src[$];
  logic [7:0]  e3 [12];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr();
    n_wr2 = 0; n_err2 = 0; n_wr4 = 0;
    n_req4 = 0; n_done4 = 0; unstable = 0;
    txq.delete();
  endtask

  // One clock: log the byte the coming edge transfers, then count pulses.
  task automatic cyc();
    logic pv, pr;
    logic [7:0] pb;
    pv = b4.tx_byte_vld;
    pr = b4.tx_byte_rdy;
    pb = b4.tx_byte;
    if (pv === 1'b1 && pr === 1'b1 && !rst4) txq.push_back(pb);
    @(negedge clk);
    if (pv === 1'b1 && pr === 1'b0 && !rst4 &&
        (b4.tx_byte_vld !== 1'b1 || b4.tx_byte !== pb))
      unstable++;
    n_wr2   += int'(b2.wr_vld);
    n_err2  += int'(b2.rx_timeout_err);
    n_wr4   += int'(b4.wr_vld);
    n_req4  += int'(b4.rd_req);
    n_done4 += int'(b4.tx_done);
  endtask

  task automatic rx2(input logic [7:0] b);
    b2.rx_byte = b;
    b2.rx_byte_vld = 1'b1;
    cyc();
    b2.rx_byte_vld = 1'b0;
  endtask

  task automatic start4(input logic [15:0] n);
    b4.burst_len = n;
    b4.tx_start = 1'b1;
    cyc();
    b4.tx_start = 1'b0;
  endtask

  // mode 0: rdy high; 1: rdy toggles every 3 cycles plus a stray start;
  // 2: reset while on byte 1 of the first word; 3: RX bytes during SEND
  task automatic run_tx(input int mode);
    int n, pend, last, widx, rxn;
    logic [7:0] rxb [4];
    bit stop;
    rxb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    n = 0; pend = -1; last = 0; widx = 0; rxn = 0; stop = 1'b0;
    while (!stop && n < 400) begin
      b4.tx_start = 1'b0;
      b4.rd_data_vld = 1'b0;
      b4.rx_byte_vld = 1'b0;
      b4.tx_byte_rdy = (mode == 1) ? ((n / 3) % 2 == 1) : 1'b1;
      if (mode == 1 && n == 10) begin
        b4.tx_start = 1'b1;
        b4.burst_len = 16'd7;
      end
      if (pend == 0) begin
        b4.rd_data = (widx < src.size()) ? src[widx] : 32'h0;
        b4.rd_data_vld = 1'b1;
        widx++;
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
      if (mode == 3 && b4.tx_byte_vld && rxn < 4) begin
        b4.rx_byte = rxb[rxn];
        b4.rx_byte_vld = 1'b1;
        rxn++;
      end
      if (mode == 2 && txq.size() == 1 && b4.tx_byte_vld) begin
        rst4 = 1'b1;
        b4.tx_byte_rdy = 1'b0;
        stop = 1'b1;
        reached = 1;
      end
      cyc();
      rst4 = 1'b0;
      if (n_req4 != last) begin
        last = n_req4;
        pend = 1;
      end
      if (mode != 2 && n_done4 != 0) stop = 1'b1;
      n++;
    end
    b4.tx_start = 1'b0;
    b4.rd_data_vld = 1'b0;
    b4.rx_byte_vld = 1'b0;
    b4.tx_byte_rdy = 1'b0;
  endtask

  initial begin
    e3 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22,
           8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    rst2 = 1'b1; rst4 = 1'b1; reached = 0;
    b2.rx_byte = '0; b2.rx_byte_vld = 1'b0; b2.tx_byte_rdy = 1'b0;
    b2.tx_start = 1'b0; b2.burst_len = '0;
    b2.rd_data = '0; b2.rd_data_vld = 1'b0;
    b4.rx_byte = '0; b4.rx_byte_vld = 1'b0; b4.tx_byte_rdy = 1'b0;
    b4.tx_start = 1'b0; b4.burst_len = '0;
    b4.rd_data = '0; b4.rd_data_vld = 1'b0;
    cyc();
    cyc();
    rst2 = 1'b0; rst4 = 1'b0;
    clr();

    chk("rst_wr_data",  b4.wr_data, 0);
    chk("rst_wr_vld",   b4.wr_vld, 0);
    chk("rst_tx_byte",  b4.tx_byte, 0);
    chk("rst_tx_vld",   b4.tx_byte_vld, 0);
    chk("rst_rd_req",   b4.rd_req, 0);
    chk("rst_busy",     b4.tx_busy, 0);
    chk("rst_done",     b4.tx_done, 0);
    chk("rst_err",      b4.rx_timeout_err, 0);
    chk("rst_rx_cnt",   b4.rx_word_cnt, 0);
    chk("rst_tx_cnt",   b4.tx_word_cnt, 0);
    chk("rst_wr_data2", b2.wr_data, 0);

    rx2(8'h34);
    repeat (5) cyc();
    rx2(8'h12);
    chk("rx1_vld",  b2.wr_vld, 1);
    chk("rx1_data", b2.wr_data, 16'h1234);
    chk("rx1_cnt",  b2.rx_word_cnt, 1);
    cyc();
    chk("rx1_pulse", b2.wr_vld, 0);
    chk("rx1_hold",  b2.wr_data, 16'h1234);

    rx2(8'hAA);
    repeat (7) cyc();
    chk("to_early", n_err2, 0);
    cyc();
    chk("to_fire", b2.rx_timeout_err, 1);
    cyc();
    chk("to_pulse", b2.rx_timeout_err, 0);
    rx2(8'h11);
    rx2(8'h22);
    chk("to_data",  b2.wr_data, 16'h2211);
    chk("to_nwr",   n_wr2, 2);
    chk("to_nerr",  n_err2, 1);
    chk("to_cnt",   b2.rx_word_cnt, 2);

    rx2(8'h5A);
    repeat (7) cyc();
    rx2(8'hC3);
    chk("win_vld",  b2.wr_vld, 1);
    chk("win_data", b2.wr_data, 16'hC35A);
    chk("win_nerr", n_err2, 1);

    clr();
    start4(16'd0);
    chk("z_done", b4.tx_done, 1);
    chk("z_busy", b4.tx_busy, 0);
    repeat (3) cyc();
    chk("z_req",   n_req4, 0);
    chk("z_busy2", b4.tx_busy, 0);
    chk("z_ndone", n_done4, 1);

    clr();
    src = '{32'hDDCCBBAA, 32'h44332211, 32'h88776655};
    start4(16'd3);
    chk("b_busy", b4.tx_busy, 1);
    run_tx(1);
    chk("b_nbytes", txq.size(), 12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("b_byte%0d", i),
          (i < txq.size()) ? txq[i] : 8'hxx, e3[i]);
    chk("b_nreq",   n_req4, 3);
    chk("b_ndone",  n_done4, 1);
    chk("b_txcnt",  b4.tx_word_cnt, 3);
    chk("b_stable", unstable, 0);
    chk("b_idle",   b4.tx_busy, 0);

    clr();
    src = '{32'h01020304, 32'h05060708};
    start4(16'd2);
    run_tx(2);
    chk("r_reached", reached, 1);
    chk("r_vld",   b4.tx_byte_vld, 0);
    chk("r_byte",  b4.tx_byte, 0);
    chk("r_req",   b4.rd_req, 0);
    chk("r_busy",  b4.tx_busy, 0);
    chk("r_done",  b4.tx_done, 0);
    chk("r_txcnt", b4.tx_word_cnt, 0);
    repeat (5) cyc();
    chk("r_ndone", n_done4, 0);
    chk("r_nreq",  n_req4, 1);
    chk("r_nbyte", txq.size(), 1);

    clr();
    src = '{32'h0A0B0C0D};
    start4(16'd1);
    run_tx(0);
    chk("a_nbyte", txq.size(), 4);
    chk("a_word", {txq[3], txq[2], txq[1], txq[0]}, 32'h0A0B0C0D);
    chk("a_ndone", n_done4, 1);
    chk("a_txcnt", b4.tx_word_cnt, 1);

    rst2 = 1'b1;
    cyc();
    rst2 = 1'b0;
    clr();
    chk("w_rst_cnt", b2.rx_word_cnt, 0);
    for (int k = 0; k < 17; k++) begin
      rx2(8'(k));
      rx2(8'(k + 8'h80));
    end
    chk("w_cnt",  b2.rx_word_cnt, 1);
    chk("w_data", b2.wr_data, 16'h9010);
    chk("w_nwr",  n_wr2, 17);

    clr();
    src = '{32'h11223344};
    start4(16'd1);
    run_tx(3);
    chk("c_nbyte", txq.size(), 4);
    chk("c_tx", {txq[3], txq[2], txq[1], txq[0]}, 32'h11223344);
    chk("c_rx",    b4.wr_data, 32'hD4C3B2A1);
    chk("c_rxcnt", b4.rx_word_cnt, 1);
    chk("c_nwr",   n_wr4, 1);
    chk("c_txcnt", b4.tx_word_cnt, 2);
    chk("c_ndone", n_done4, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
